// File: rtl/ex_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ex_pkg
//  Brief    : Operation codes, result-select codes and divider state type
//             shared by the execute stage, its divider and its bus interface.
//  Revision : 1.0  initial release
// ============================================================================
package ex_pkg;

    // aluop codes
    localparam logic [7:0] c_aluop_and  = 8'h24;
    localparam logic [7:0] c_aluop_or   = 8'h25;
    localparam logic [7:0] c_aluop_xor  = 8'h26;
    localparam logic [7:0] c_aluop_nor  = 8'h27;
    localparam logic [7:0] c_aluop_sll  = 8'h7C;
    localparam logic [7:0] c_aluop_srl  = 8'h02;
    localparam logic [7:0] c_aluop_sra  = 8'h03;
    localparam logic [7:0] c_aluop_add  = 8'h20;
    localparam logic [7:0] c_aluop_addu = 8'h21;
    localparam logic [7:0] c_aluop_sub  = 8'h22;
    localparam logic [7:0] c_aluop_subu = 8'h23;
    localparam logic [7:0] c_aluop_slt  = 8'h2A;
    localparam logic [7:0] c_aluop_sltu = 8'h2B;
    localparam logic [7:0] c_aluop_div  = 8'h1A;
    localparam logic [7:0] c_aluop_divu = 8'h1B;

    // alusel codes
    localparam logic [2:0] c_sel_logic = 3'd1;
    localparam logic [2:0] c_sel_shift = 3'd2;
    localparam logic [2:0] c_sel_arith = 3'd3;
    localparam logic [2:0] c_sel_div   = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage
`default_nettype wire

// File: rtl/ex_pipe_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ex_pipe_if
//  Brief    : ID/EX-to-execute bus and EX/MEM result bus. ovf_o exists only
//             when EX_OVF_TRAP_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
interface ex_pipe_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALUOP_W    = 8,
    parameter int ALUSEL_W   = 3
);
    logic                  flush_i;
    logic                  stall_i;
    logic                  valid_i;
    logic [ALUOP_W-1:0]    aluop_i;
    logic [ALUSEL_W-1:0]   alusel_i;
    logic [DATA_W-1:0]     reg1_i;
    logic [DATA_W-1:0]     reg2_i;
    logic [REG_ADDR_W-1:0] wd_i;
    logic                  wreg_i;

    logic                  valid_o;
    logic [REG_ADDR_W-1:0] wd_o;
    logic                  wreg_o;
    logic [DATA_W-1:0]     wdata_o;
    logic                  hilo_we_o;
    logic [DATA_W-1:0]     hi_o;
    logic [DATA_W-1:0]     lo_o;
    logic                  stallreq_o;
`ifdef EX_OVF_TRAP_EN
    logic                  ovf_o;
`endif

    modport master (
        output flush_i, stall_i, valid_i, aluop_i, alusel_i,
               reg1_i, reg2_i, wd_i, wreg_i,
        input  valid_o, wd_o, wreg_o, wdata_o, hilo_we_o, hi_o, lo_o, stallreq_o
`ifdef EX_OVF_TRAP_EN
        , input ovf_o
`endif
    );

    modport slave (
        input  flush_i, stall_i, valid_i, aluop_i, alusel_i,
               reg1_i, reg2_i, wd_i, wreg_i,
        output valid_o, wd_o, wreg_o, wdata_o, hilo_we_o, hi_o, lo_o, stallreq_o
`ifdef EX_OVF_TRAP_EN
        , output ovf_o
`endif
    );
endinterface
`default_nettype wire

// File: rtl/ex_pipe_div_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : div_unit
//  Brief    : Radix-2 restoring divider, one quotient bit per cycle, with
//             signed magnitude fix-up and an IDLE/BUSY/DONE control FSM.
//  Revision : 1.0  initial release
// ============================================================================
module div_unit
    import ex_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              flush,
    input  wire logic              hold,
    input  wire logic              start,
    input  wire logic              is_signed,
    input  wire logic [DATA_W-1:0] a,
    input  wire logic [DATA_W-1:0] b,
    output logic                   busy,
    output logic                   done,
    output logic [DATA_W-1:0]      quo,
    output logic [DATA_W-1:0]      rem
);
    localparam int c_cnt_w = $clog2(DATA_W);

    div_state_t          r_state;
    div_state_t          w_next;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [DATA_W-1:0]   r_quo;
    logic [DATA_W-1:0]   r_rem;
    logic [DATA_W-1:0]   r_div;
    logic                r_neg_q;
    logic                r_neg_r;
    logic                r_dvz;

    logic [DATA_W-1:0]   w_a_mag;
    logic [DATA_W-1:0]   w_b_mag;
    logic [DATA_W:0]     w_shift;
    logic [DATA_W:0]     w_diff;

    assign w_a_mag = (is_signed && a[DATA_W-1]) ? -a : a;
    assign w_b_mag = (is_signed && b[DATA_W-1]) ? -b : b;
    assign w_shift = {r_rem, r_quo[DATA_W-1]};
    assign w_diff  = w_shift - {1'b0, r_div};

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = BUSY;
            BUSY:    if (flush) w_next = IDLE;
                     else if (r_cnt == '0) w_next = DONE;
            DONE:    if (flush || !hold) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_div   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dvz   <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_cnt   <= c_cnt_w'(DATA_W - 1);
            r_quo   <= w_a_mag;
            r_rem   <= '0;
            r_div   <= w_b_mag;
            r_neg_q <= is_signed && (a[DATA_W-1] ^ b[DATA_W-1]);
            r_neg_r <= is_signed && a[DATA_W-1];
            r_dvz   <= (b == '0);
        end else if (r_state == BUSY && !flush) begin
            r_cnt <= r_cnt - 1'b1;
            if (!w_diff[DATA_W]) begin
                r_rem <= w_diff[DATA_W-1:0];
                r_quo <= {r_quo[DATA_W-2:0], 1'b1};
            end else begin
                r_rem <= w_shift[DATA_W-1:0];
                r_quo <= {r_quo[DATA_W-2:0], 1'b0};
            end
        end
    end

    // A zero divisor leaves |a| in the remainder, so the sign fix-up restores a.
    assign quo  = r_dvz ? '1 : (r_neg_q ? -r_quo : r_quo);
    assign rem  = r_neg_r ? -r_rem : r_rem;
    assign busy = (r_state == BUSY);
    assign done = (r_state == DONE);

endmodule
`default_nettype wire

// File: rtl/ex_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ex_pipe
//  Brief    : Execute stage with EX/MEM output register; single-cycle logic,
//             shift and arith ops, multi-cycle divide with stall request.
//             Optional macro EX_OVF_TRAP_EN adds signed-overflow trap (ovf_o).
//  Revision : 1.0  initial release
// ============================================================================
module ex_pipe
    import ex_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALUOP_W    = 8,
    parameter int ALUSEL_W   = 3
) (
    input wire logic clk,
    input wire logic rst,
    ex_pipe_if.slave bus
);
    localparam int c_sh_w = $clog2(DATA_W);

    logic [ALUOP_W-1:0]  w_aluop;
    logic [ALUSEL_W-1:0] w_alusel;
    logic [7:0]          w_op;
    logic [2:0]          w_sel;
    logic [DATA_W-1:0]   w_a;
    logic [DATA_W-1:0]   w_b;
    logic [c_sh_w-1:0]   w_shamt;
    logic [DATA_W-1:0]   w_sum;
    logic [DATA_W-1:0]   w_dif;
    logic [DATA_W-1:0]   w_result;
    logic                w_known;
    logic                w_is_div;
    logic                w_start;
    logic                w_div_busy;
    logic                w_div_done;
    logic [DATA_W-1:0]   w_quo;
    logic [DATA_W-1:0]   w_rem;

    logic                  r_valid;
    logic [REG_ADDR_W-1:0] r_wd;
    logic                  r_wreg;
    logic [DATA_W-1:0]     r_wdata;
    logic                  r_hilo_we;
    logic [DATA_W-1:0]     r_hi;
    logic [DATA_W-1:0]     r_lo;

    assign w_aluop  = bus.aluop_i;
    assign w_alusel = bus.alusel_i;
    assign w_op     = 8'(w_aluop);
    assign w_sel    = 3'(w_alusel);
    assign w_a      = bus.reg1_i;
    assign w_b      = bus.reg2_i;
    assign w_shamt  = w_a[c_sh_w-1:0];
    assign w_sum    = w_a + w_b;
    assign w_dif    = w_a - w_b;

    always_comb begin
        w_result = '0;
        w_known  = 1'b0;
        case (w_sel)
            c_sel_logic: begin
                w_known = 1'b1;
                case (w_op)
                    c_aluop_and: w_result = w_a & w_b;
                    c_aluop_or:  w_result = w_a | w_b;
                    c_aluop_xor: w_result = w_a ^ w_b;
                    c_aluop_nor: w_result = ~(w_a | w_b);
                    default:     w_known  = 1'b0;
                endcase
            end
            c_sel_shift: begin
                w_known = 1'b1;
                case (w_op)
                    c_aluop_sll: w_result = w_b << w_shamt;
                    c_aluop_srl: w_result = w_b >> w_shamt;
                    c_aluop_sra: w_result = $unsigned($signed(w_b) >>> w_shamt);
                    default:     w_known  = 1'b0;
                endcase
            end
            c_sel_arith: begin
                w_known = 1'b1;
                case (w_op)
                    c_aluop_add, c_aluop_addu: w_result = w_sum;
                    c_aluop_sub, c_aluop_subu: w_result = w_dif;
                    c_aluop_slt:  w_result = {{(DATA_W-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
                    c_aluop_sltu: w_result = {{(DATA_W-1){1'b0}}, (w_a < w_b)};
                    default:      w_known  = 1'b0;
                endcase
            end
            default: ;
        endcase
    end

`ifdef EX_OVF_TRAP_EN
    logic w_ovf;
    logic r_ovf;
    assign w_ovf = (w_sel == c_sel_arith) &&
                   (((w_op == c_aluop_add) && (w_a[DATA_W-1] == w_b[DATA_W-1]) &&
                     (w_sum[DATA_W-1] != w_a[DATA_W-1])) ||
                    ((w_op == c_aluop_sub) && (w_a[DATA_W-1] != w_b[DATA_W-1]) &&
                     (w_dif[DATA_W-1] != w_a[DATA_W-1])));
`endif

    assign w_is_div = bus.valid_i && (w_sel == c_sel_div) &&
                      ((w_op == c_aluop_div) || (w_op == c_aluop_divu));
    assign w_start  = w_is_div && !w_div_busy && !w_div_done && !bus.flush_i && !bus.stall_i;

    div_unit #(.DATA_W(DATA_W)) u_div (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.flush_i),
        .hold      (bus.stall_i),
        .start     (w_start),
        .is_signed (w_op == c_aluop_div),
        .a         (w_a),
        .b         (w_b),
        .busy      (w_div_busy),
        .done      (w_div_done),
        .quo       (w_quo),
        .rem       (w_rem)
    );

    // Raised in the accepting cycle already so ID/EX holds the divide operands.
    assign bus.stallreq_o = (w_is_div && !w_div_busy && !w_div_done) || w_div_busy;

    always_ff @(posedge clk) begin
        if (rst || bus.flush_i) begin
            r_valid   <= 1'b0;
            r_wd      <= '0;
            r_wreg    <= 1'b0;
            r_wdata   <= '0;
            r_hilo_we <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
`ifdef EX_OVF_TRAP_EN
            r_ovf     <= 1'b0;
`endif
        end else if (!bus.stall_i) begin
            r_hilo_we <= w_div_done;
            r_hi      <= w_div_done ? w_rem : '0;
            r_lo      <= w_div_done ? w_quo : '0;
            if (w_div_done) begin
                r_valid <= 1'b1;
                r_wd    <= '0;
                r_wreg  <= 1'b0;
                r_wdata <= '0;
            end else if (bus.valid_i && w_known && !w_div_busy) begin
                r_valid <= 1'b1;
                r_wd    <= bus.wd_i;
`ifdef EX_OVF_TRAP_EN
                r_wreg  <= bus.wreg_i && !w_ovf;
`else
                r_wreg  <= bus.wreg_i;
`endif
                r_wdata <= w_result;
            end else begin
                r_valid <= 1'b0;
                r_wd    <= '0;
                r_wreg  <= 1'b0;
                r_wdata <= '0;
            end
`ifdef EX_OVF_TRAP_EN
            r_ovf <= bus.valid_i && w_known && !w_div_busy && !w_div_done && w_ovf;
`endif
        end
    end

    assign bus.valid_o   = r_valid;
    assign bus.wd_o      = r_wd;
    assign bus.wreg_o    = r_wreg;
    assign bus.wdata_o   = r_wdata;
    assign bus.hilo_we_o = r_hilo_we;
    assign bus.hi_o      = r_hi;
    assign bus.lo_o      = r_lo;
`ifdef EX_OVF_TRAP_EN
    assign bus.ovf_o     = r_ovf;
`endif

endmodule
`default_nettype wire
